// File: rtl/trace_buf_pkg.sv
// Shared types and constants for the trace buffer capture path.
package trace_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int TRACE_BUF_ADDR_W     = 15;
    localparam int TRACE_BUF_RD_LATENCY = 1;

endpackage

// File: rtl/trace_buf_rd_port.sv
// Port B readout: accepts host reads in DONE, forms start+offset, and delays
// the request to line up rd_valid with the BRAM read data.
module trace_buf_rd_port
    import trace_buf_pkg::*;
#(
    parameter int ADDR_W = TRACE_BUF_ADDR_W,
    parameter int RD_LAT = TRACE_BUF_RD_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              rd_allow,
    input  logic              wrapped,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [ADDR_W-1:0] rd_offset,
    output logic [ADDR_W-1:0] addrb,
    output logic              rd_valid
);

    logic              rd_accept;
    logic [ADDR_W-1:0] rd_start;
    logic [RD_LAT:0]   vld_pipe;

    // rd_req is a single-cycle request without backpressure: when accepted,
    // addrb updates on the next edge and rd_valid pulses RD_LAT cycles later.
    assign rd_accept = rd_req && rd_allow;
    assign rd_start  = wrapped ? wr_ptr : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrb    <= '0;
            vld_pipe <= '0;
        end else begin
            if (rd_accept) begin
                addrb <= rd_start + rd_offset;
            end
            vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_accept};
        end
    end

    assign rd_valid = vld_pipe[RD_LAT];

endmodule

// File: rtl/trace_buf_capture_ctrl.sv
// Armed, trigger-based capture sequencer for the trace buffer BRAM.
// Build option TRACE_BUF_PRETRIG_EN: circular pre-trigger capture while ARMED.
module trace_buf_capture_ctrl
    import trace_buf_pkg::*;
#(
    parameter int TRACE_BUF_ADDR_WIDTH = TRACE_BUF_ADDR_W,
    parameter int TRACE_BUF_DATA_WIDTH = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_en_100ns,
    input  logic                            arm,
    input  logic                            abort,
    input  logic                            trigger,
    input  logic [TRACE_BUF_ADDR_WIDTH-1:0] post_trig_len,
    input  logic                            rd_req,
    input  logic [TRACE_BUF_ADDR_WIDTH-1:0] rd_offset,
    output logic [TRACE_BUF_ADDR_WIDTH-1:0] trace_buf_bram_addra,
    output logic                            trace_buf_we,
    output logic [TRACE_BUF_ADDR_WIDTH-1:0] trace_buf_bram_addrb,
    output logic                            trace_buf_en,
    output logic                            rd_valid,
    output logic [TRACE_BUF_ADDR_WIDTH-1:0] trig_addr,
    output logic                            busy,
    output logic                            capture_done,
    output logic                            wrapped,
    output trace_state_e                    state_dbg
);

    localparam int AW = TRACE_BUF_ADDR_WIDTH;

    // The data path lives entirely in the BRAM; only sanity-check the width.
    if (TRACE_BUF_DATA_WIDTH < 1) begin : g_bad_data_width
        $error("TRACE_BUF_DATA_WIDTH must be positive");
    end

    trace_state_e  state, state_nx;
    logic [AW-1:0] wr_ptr, wr_ptr_nx;
    logic [AW-1:0] post_cnt, post_cnt_nx;
    logic [AW-1:0] post_len, post_len_nx;
    logic [AW-1:0] trig_addr_nx;
    logic [AW-1:0] wr_addr;
    logic          wrapped_nx;
    logic          wr_en;

    always_comb begin
        state_nx     = state;
        wr_ptr_nx    = wr_ptr;
        post_cnt_nx  = post_cnt;
        post_len_nx  = post_len;
        trig_addr_nx = trig_addr;
        wrapped_nx   = wrapped;
        wr_addr      = wr_ptr;
        wr_en        = 1'b0;

        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_nx    = ST_ARMED;
                        wr_ptr_nx   = '0;
                        post_cnt_nx = '0;
                        wrapped_nx  = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (trigger) begin
                        state_nx    = ST_POST;
                        post_len_nx = post_trig_len;
                        post_cnt_nx = '0;
`ifdef TRACE_BUF_PRETRIG_EN
                        trig_addr_nx = wr_ptr;
`else
                        // No pre-trigger history: the capture restarts at address 0.
                        trig_addr_nx = '0;
                        wr_addr      = '0;
                        wr_ptr_nx    = '0;
`endif
                        // A strobe coincident with the trigger is the first post sample.
                        if (rd_en_100ns && (post_trig_len != '0)) begin
                            wr_en       = 1'b1;
                            post_cnt_nx = AW'(1);
                        end
                    end
`ifdef TRACE_BUF_PRETRIG_EN
                    else if (rd_en_100ns) begin
                        wr_en = 1'b1;
                    end
`endif
                end
                ST_POST: begin
                    if (post_cnt == post_len) begin
                        state_nx = ST_DONE;
                    end else if (rd_en_100ns) begin
                        wr_en       = 1'b1;
                        post_cnt_nx = post_cnt + AW'(1);
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end

        if (wr_en) begin
            wr_ptr_nx = wr_addr + AW'(1);
            if (&wr_addr) begin
`ifdef TRACE_BUF_PRETRIG_EN
                wrapped_nx = 1'b1;
`else
                // Buffer full: stop rather than overwrite the trigger sample.
                if (state_nx == ST_POST) begin
                    state_nx = ST_DONE;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            wr_ptr               <= '0;
            post_cnt             <= '0;
            post_len             <= '0;
            trig_addr            <= '0;
            wrapped              <= 1'b0;
            trace_buf_we         <= 1'b0;
            trace_buf_bram_addra <= '0;
            busy                 <= 1'b0;
            capture_done         <= 1'b0;
        end else begin
            state        <= state_nx;
            wr_ptr       <= wr_ptr_nx;
            post_cnt     <= post_cnt_nx;
            post_len     <= post_len_nx;
            trig_addr    <= trig_addr_nx;
            wrapped      <= wrapped_nx;
            trace_buf_we <= wr_en;
            if (wr_en) begin
                trace_buf_bram_addra <= wr_addr;
            end
            busy         <= (state_nx == ST_ARMED) || (state_nx == ST_POST);
            capture_done <= (state_nx == ST_DONE);
        end
    end

    assign trace_buf_en = 1'b1;
    assign state_dbg    = state;

    trace_buf_rd_port #(
        .ADDR_W (AW),
        .RD_LAT (TRACE_BUF_RD_LATENCY)
    ) u_rd_port (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_allow  ((state == ST_DONE) && !abort),
        .wrapped   (wrapped),
        .wr_ptr    (wr_ptr),
        .rd_offset (rd_offset),
        .addrb     (trace_buf_bram_addrb),
        .rd_valid  (rd_valid)
    );

endmodule
